motor_dir_sequencer: RTL and testbench



---
 rtl/motor_dir_sequencer.sv | 155 +++++++++++++++
 tb/tb_motor_dir_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/motor_dir_sequencer.sv
// motor_dir_sequencer: direction command sequencer for the motor drive.
// Adds a fixed dead-time (sel_out=00) between any running direction and
// a stop or reversal, and latches faults until explicitly acknowledged.
// Optional build macro MOTOR_SEQ_FAULT_CNT_EN adds a saturating fault_count
// output; the default build leaves the port and counter out.
module motor_dir_sequencer #(
    parameter int DEAD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cmd,
    input  logic       fault_in,
    input  logic       fault_clr,
    output logic [1:0] sel_out,
    output logic       busy,
    output logic       fault,
`ifdef MOTOR_SEQ_FAULT_CNT_EN
    output logic [7:0] fault_count,
`endif
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CW    = 3'd1,
        CCW   = 3'd2,
        DEAD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Terminal count: the counter starts at 0, so DEAD lasts DEAD_CYCLES cycles.
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    state_t           state_reg, state_next;
    state_t           target_reg, target_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             fault_entry;

    // Map a command onto the state it requests; 11 never gets here because
    // it is diverted to FAULT first.
    function automatic state_t cmd_target(input logic [1:0] c);
        case (c)
            2'b01:   return CW;
            2'b10:   return CCW;
            default: return IDLE;
        endcase
    endfunction

    // State, dead-time counter and pending target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            target_reg <= IDLE;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Next-state logic: fault entry beats every normal transition.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        cnt_next    = cnt_reg;
        fault_entry = fault_in || (cmd == 2'b11);

        if (fault_entry) begin
            // Also aborts a dead-time in progress.
            state_next = FAULT;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // Output already off, so a direction starts immediately.
                    state_next = cmd_target(cmd);
                end
                CW: begin
                    if (cmd != 2'b01) begin
                        state_next  = DEAD;
                        target_next = cmd_target(cmd);
                        cnt_next    = '0;
                    end
                end
                CCW: begin
                    if (cmd != 2'b10) begin
                        state_next  = DEAD;
                        target_next = cmd_target(cmd);
                        cnt_next    = '0;
                    end
                end
                DEAD: begin
                    // Target follows cmd every cycle; the count is never disturbed.
                    target_next = cmd_target(cmd);
                    if (cnt_reg == DEAD_LAST) begin
                        state_next = cmd_target(cmd);
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                FAULT: begin
                    // fault_in is already known low here.
                    if (fault_clr && (cmd == 2'b00)) begin
                        state_next  = DEAD;
                        target_next = IDLE;
                        cnt_next    = '0;
                    end
                end
                default: begin
                    state_next  = IDLE;
                    target_next = IDLE;
                    cnt_next    = '0;
                end
            endcase
        end
    end

    // Direction select: bit 0 is CW, bit 1 is CCW, so 11 cannot be decoded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sel
            assign sel_out[gi] = (state_reg == ((gi == 0) ? CW : CCW));
        end
    endgenerate

    assign busy    = (state_reg == DEAD);
    assign fault   = (state_reg == FAULT);
    assign state_o = state_reg;

`ifdef MOTOR_SEQ_FAULT_CNT_EN
    logic [7:0] fault_count_reg;

    // Count entries into FAULT from any other state, saturating at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count_reg <= '0;
        end else if ((state_next == FAULT) && (state_reg != FAULT) &&
                     (fault_count_reg != 8'hFF)) begin
            fault_count_reg <= fault_count_reg + 8'd1;
        end
    end

    assign fault_count = fault_count_reg;
`endif

    // Both directions selected at once would short the drive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (sel_out != 2'b11);
        end
    end

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// Directed testbench for motor_dir_sequencer with DEAD_CYCLES=4.
module tb_motor_dir_sequencer;

    logic       clk;
    logic       rst;
    logic [1:0] cmd;
    logic       fault_in;
    logic       fault_clr;
    logic [1:0] sel_out;
    logic       busy;
    logic       fault;
    logic [2:0] state_o;
`ifdef MOTOR_SEQ_FAULT_CNT_EN
    logic [7:0] fault_count;
`endif

    int n_checks;
    int n_fail;

    motor_dir_sequencer #(
        .DEAD_CYCLES(4),
        .CNT_W      (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd        (cmd),
        .fault_in   (fault_in),
        .fault_clr  (fault_clr),
        .sel_out    (sel_out),
        .busy       (busy),
        .fault      (fault),
`ifdef MOTOR_SEQ_FAULT_CNT_EN
        .fault_count(fault_count),
`endif
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance one edge and settle before sampling outputs.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        cmd       = 2'b00;
        fault_in  = 1'b0;
        fault_clr = 1'b0;
        step(2);
        rst = 1'b0;

        // Reset state
        check_val("rst_state", state_o, 0);
        check_val("rst_sel", sel_out, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_fault", fault, 0);
`ifdef MOTOR_SEQ_FAULT_CNT_EN
        check_val("rst_fcnt", fault_count, 0);
`endif

        // 1. Start-up: CW after one edge, no dead-time
        cmd = 2'b01;
        check_val("start_sel_pre", sel_out, 0);
        step();
        check_val("start_sel", sel_out, 1);
        check_val("start_state", state_o, 1);
        check_val("start_busy", busy, 0);

        // 2. Reversal CW->CCW: exactly 4 dead cycles
        cmd = 2'b10;
        step();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("rev_dead%0d_sel", i), sel_out, 0);
            check_val($sformatf("rev_dead%0d_busy", i), busy, 1);
            step();
        end
        check_val("rev_sel", sel_out, 2);
        check_val("rev_state", state_o, 2);
        check_val("rev_busy", busy, 0);

        // 3. Target change during dead-time: back to CW first
        cmd = 2'b01;
        step(5);
        check_val("tc_cw_state", state_o, 1);
        cmd = 2'b10;
        step();
        step(2);
        cmd = 2'b00;
        step();
        check_val("tc_last_dead", state_o, 3);
        step();
        check_val("tc_state", state_o, 0);
        check_val("tc_sel", sel_out, 0);

        // 4. Fault recovery from CCW
        cmd = 2'b10;
        step();
        check_val("fr_ccw", state_o, 2);
        fault_in = 1'b1;
        step();
        fault_in = 1'b0;
        check_val("fr_sel", sel_out, 0);
        check_val("fr_fault", fault, 1);
        check_val("fr_state", state_o, 4);
        fault_clr = 1'b1;
        cmd = 2'b01;
        step();
        check_val("fr_clr_cw_ignored", state_o, 4);
        cmd = 2'b00;
        step();
        fault_clr = 1'b0;
        check_val("fr_dead_state", state_o, 3);
        check_val("fr_dead_fault", fault, 0);
        check_val("fr_dead_busy", busy, 1);
        step(3);
        check_val("fr_dead4", state_o, 3);
        step();
        check_val("fr_idle", state_o, 0);
        check_val("fr_idle_fault", fault, 0);

        // 5. Illegal command from a fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        cmd = 2'b11;
        step();
        check_val("ill_state", state_o, 4);
`ifdef MOTOR_SEQ_FAULT_CNT_EN
        check_val("ill_fcnt", fault_count, 1);
`endif
        step(10);
        check_val("ill_hold_state", state_o, 4);
`ifdef MOTOR_SEQ_FAULT_CNT_EN
        check_val("ill_hold_fcnt", fault_count, 1);
`endif
        // Fault during DEAD aborts it immediately
        cmd = 2'b00;
        fault_clr = 1'b1;
        step();
        check_val("abort_dead", state_o, 3);
        cmd = 2'b11;
        step();
        check_val("abort_fault", state_o, 4);
        for (int i = 0; i < 298; i++) begin
            cmd = 2'b00;
            step();
            cmd = 2'b11;
            step();
        end
        check_val("sat_state", state_o, 4);
`ifdef MOTOR_SEQ_FAULT_CNT_EN
        check_val("sat_fcnt", fault_count, 255);
`endif
        fault_clr = 1'b0;

        // 6. Reset during the 2nd dead cycle
        rst = 1'b1;
        cmd = 2'b00;
        step();
        rst = 1'b0;
        cmd = 2'b01;
        step();
        cmd = 2'b10;
        step(2);
        check_val("mr_dead", state_o, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mr_state", state_o, 0);
        check_val("mr_sel", sel_out, 0);
        check_val("mr_busy", busy, 0);
        cmd = 2'b01;
        step();
        check_val("mr_cw_state", state_o, 1);
        check_val("mr_cw_sel", sel_out, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
